// File: rtl/rfft_seq_ctrl.sv
// Sequencer around the 256-point radix-4 FFT core: loads twiddles and samples, runs the core, streams results out.
// Latency: load writes reach the core in the handshake cycle; core RAM reads return one cycle later into a 2-entry output FIFO.
// Backpressure: tf_ready/s_ready are high only in their load state; reads issue only while FIFO occupancy plus in-flight is below 2.
//
// Ports:
//   Clk, Reset                 clock (rising edge), asynchronous active-high reset
//   start, tf_reload           frame request, sampled in IDLE only; tf_reload=1 loads twiddles first
//   tf_valid/tf_ready/tf_data  twiddle word stream
//   s_valid/s_ready/s_data     sample word stream, lane0 in LSBs
//   m_valid/m_ready/m_data     result word stream, m_last marks the final word of the frame
//   busy, frame_done           status: not idle, one-cycle pulse after the last result is accepted
//   timeout_err, run_cycles    sticky RUN timeout flag, length of the last RUN phase
//   fft_*                      core control pins, owned entirely by this block
//
// Build option: define RFFT_SEQ_PERF_EN to build the RUN cycle counter behind run_cycles;
// without it run_cycles is tied to zero.

// Small generic synchronous FIFO, power-of-two depth.
module rfft_seq_fifo #(
   parameter int  W     = 64,
   parameter int  DEPTH = 2,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [W-1:0]  in_dat,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [W-1:0]  out_dat,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   assign in_rdy  = (count != CW'(DEPTH));
   assign out_vld = (count != '0);
   assign push    = in_vld && in_rdy;
   assign pop     = out_vld && out_rdy;
   assign out_dat = mem[rd_ptr];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= in_dat;
   end
endmodule

module rfft_seq_ctrl #(
   parameter int WIDTH       = 16,
   parameter int NWORDS      = 64,
   parameter int TF_WORDS    = 128,
   parameter int RUN_TIMEOUT = 1023
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic               tf_reload,
   input  logic               tf_valid,
   output logic               tf_ready,
   input  logic [2*WIDTH-1:0] tf_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [4*WIDTH-1:0] s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [4*WIDTH-1:0] m_data,
   output logic               m_last,
   output logic               busy,
   output logic               frame_done,
   output logic               timeout_err,
   output logic [15:0]        run_cycles,
   output logic               fft_input,
   output logic               fft_write,
   output logic [5:0]         fft_addr,
   output logic [4*WIDTH-1:0] fft_din,
   output logic               fft_tf_we,
   output logic [7:0]         fft_addr_t,
   input  logic [4*WIDTH-1:0] fft_dout,
   input  logic               fft_done
);
   localparam int             RCW      = $clog2(RUN_TIMEOUT + 1);
   localparam logic [7:0]     TF_LAST  = 8'(TF_WORDS - 1);
   localparam logic [5:0]     W_LAST   = 6'(NWORDS - 1);
   localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD_TF, S_LOAD_DATA, S_RUN, S_READ} state_t;
   state_t state, state_nxt;

   logic [7:0]     tf_cnt;
   logic [5:0]     wr_cnt;
   logic [6:0]     iss_cnt;      // read addresses issued, 0..NWORDS
   logic [5:0]     out_cnt;      // result words accepted downstream
   logic [RCW-1:0] run_cnt;
   logic           rd_inflight;  // read issued last cycle, data on fft_dout now
   logic           rd_issue;
   logic           last_hs;
   logic           timeout_hit;
   logic           fifo_in_rdy;
   logic [1:0]     fifo_cnt;

   rfft_seq_fifo #(.W(4*WIDTH), .DEPTH(2)) u_out_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .in_vld  (rd_inflight),
      .in_rdy  (fifo_in_rdy),
      .in_dat  (fft_dout),
      .out_vld (m_valid),
      .out_rdy (m_ready),
      .out_dat (m_data),
      .count   (fifo_cnt)
   );

   assign m_last      = m_valid && (out_cnt == W_LAST);
   assign last_hs     = m_last && m_ready;
   assign busy        = (state != S_IDLE);
   assign timeout_hit = (state == S_RUN) && !fft_done && (run_cnt == RUN_LAST);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tf_ready   = 1'b0;
      s_ready    = 1'b0;
      fft_input  = 1'b1;
      fft_write  = 1'b0;
      fft_tf_we  = 1'b0;
      fft_addr   = '0;
      fft_addr_t = '0;
      fft_din    = '0;
      rd_issue   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = tf_reload ? S_LOAD_TF : S_LOAD_DATA;
         end
         S_LOAD_TF: begin
            // The core's twiddle write port shares the low two lanes of the data input bus.
            tf_ready   = 1'b1;
            fft_tf_we  = tf_valid;
            fft_addr_t = tf_cnt;
            fft_din    = {{(2*WIDTH){1'b0}}, tf_data};
            if (tf_valid && tf_cnt == TF_LAST) state_nxt = S_LOAD_DATA;
         end
         S_LOAD_DATA: begin
            s_ready   = 1'b1;
            fft_write = s_valid;
            fft_addr  = wr_cnt;
            fft_din   = s_data;
            if (s_valid && wr_cnt == W_LAST) state_nxt = S_RUN;
         end
         S_RUN: begin
            fft_input = 1'b0;
            if (fft_done)         state_nxt = S_READ;
            else if (timeout_hit) state_nxt = S_IDLE;
         end
         S_READ: begin
            // Occupancy is counted before this cycle's pop, so a free slot is guaranteed for every read.
            rd_issue = (iss_cnt < 7'(NWORDS)) && fifo_in_rdy &&
                       ((fifo_cnt + 2'(rd_inflight)) < 2'd2);
            fft_addr = iss_cnt[5:0];
            if (last_hs) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         tf_cnt      <= '0;
         wr_cnt      <= '0;
         iss_cnt     <= '0;
         out_cnt     <= '0;
         run_cnt     <= '0;
         rd_inflight <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         rd_inflight <= rd_issue;
         frame_done  <= (state == S_READ) && last_hs;

         if (state == S_IDLE && start) timeout_err <= 1'b0;
         else if (timeout_hit)         timeout_err <= 1'b1;

         if (state == S_LOAD_TF && tf_valid)
            tf_cnt <= (tf_cnt == TF_LAST) ? '0 : tf_cnt + 1'b1;
         if (state == S_LOAD_DATA && s_valid)
            wr_cnt <= (wr_cnt == W_LAST) ? '0 : wr_cnt + 1'b1;

         if (state == S_RUN && state_nxt == S_RUN) run_cnt <= run_cnt + 1'b1;
         else                                      run_cnt <= '0;

         if (state == S_READ && state_nxt != S_READ) iss_cnt <= '0;
         else if (rd_issue)                          iss_cnt <= iss_cnt + 1'b1;

         if (m_valid && m_ready)
            out_cnt <= (out_cnt == W_LAST) ? '0 : out_cnt + 1'b1;
      end
   end

`ifdef RFFT_SEQ_PERF_EN
   logic [15:0] perf_cnt;

   // Cleared on RUN entry, so it holds the previous RUN length until the next one starts.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                                     perf_cnt <= '0;
      else if (state != S_RUN && state_nxt == S_RUN) perf_cnt <= '0;
      else if (state == S_RUN && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 1'b1;
   end

   assign run_cycles = perf_cnt;
`else
   assign run_cycles = '0;
`endif
endmodule

// File: tb/tb_rfft_seq_ctrl.sv
// Directed bench for rfft_seq_ctrl with a behavioural FFT-core model (registered RAM read, programmable done).
// Inputs change on the falling edge; outputs are sampled 1 time unit later and tallied per cycle.
// Scenarios: reset, full frame with twiddles and random m_ready, RUN timeout, reset mid-load, back-to-back frame.
module tb_rfft_seq_ctrl;
   logic        Clk, Reset;
   logic        start, tf_reload;
   logic        tf_valid, tf_ready;
   logic [31:0] tf_data;
   logic        s_valid, s_ready;
   logic [63:0] s_data;
   logic        m_valid, m_ready, m_last;
   logic [63:0] m_data;
   logic        busy, frame_done, timeout_err;
   logic [15:0] run_cycles;
   logic        fft_input, fft_write, fft_tf_we;
   logic [5:0]  fft_addr;
   logic [7:0]  fft_addr_t;
   logic [63:0] fft_din, fft_dout;
   logic        fft_done;

   rfft_seq_ctrl dut (
      .Clk(Clk), .Reset(Reset), .start(start), .tf_reload(tf_reload),
      .tf_valid(tf_valid), .tf_ready(tf_ready), .tf_data(tf_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .run_cycles(run_cycles),
      .fft_input(fft_input), .fft_write(fft_write), .fft_addr(fft_addr), .fft_din(fft_din),
      .fft_tf_we(fft_tf_we), .fft_addr_t(fft_addr_t), .fft_dout(fft_dout), .fft_done(fft_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [63:0] dmodel(input logic [5:0] a);
      return {10'h3C0, a, 10'h2A5, a, 10'h15A, a, 10'h0F0, a};
   endfunction

   function automatic logic [63:0] smodel(input logic [5:0] a);
      return {10'h111, a, 10'h222, a, 10'h333, a, 10'h044, a};
   endfunction

   // Core model: registered read port, done raised in the 470th RUN cycle when enabled.
   logic done_en;
   int   rc;
   always @(posedge Clk) begin
      fft_dout <= dmodel(fft_addr);
      rc       <= fft_input ? 0 : rc + 1;
   end
   assign fft_done = done_en && !fft_input && (rc == 469);

   int   checks, errors;
   int   tf_we_n, tf_bad, wr_n, wr_bad, run_n, rx_n, rx_bad, hold_bad, fd_n, fd_bad;
   logic fd_exp, prev_pend, rnd_ready;
   logic [63:0] prev_dat;

   task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
      end
   endtask

   task automatic clr();
      tf_we_n = 0; tf_bad = 0; wr_n = 0; wr_bad = 0; run_n = 0;
      rx_n = 0; rx_bad = 0; hold_bad = 0; fd_n = 0; fd_bad = 0;
      fd_exp = 1'b0; prev_pend = 1'b0; prev_dat = '0;
   endtask

   // Called right after the falling edge: drives m_ready, then samples one cycle's worth of outputs.
   task automatic obs();
      m_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (fft_tf_we) begin
         if (fft_addr_t !== tf_we_n[7:0] || fft_din !== {32'h0, 32'(tf_we_n)}) tf_bad++;
         tf_we_n++;
      end
      if (fft_write) begin
         if (fft_addr !== wr_n[5:0] || fft_din !== smodel(wr_n[5:0])) wr_bad++;
         wr_n++;
      end
      if (!fft_input) run_n++;
      if (prev_pend && (!m_valid || m_data !== prev_dat)) hold_bad++;
      if (frame_done !== fd_exp) fd_bad++;
      if (frame_done) fd_n++;
      fd_exp = 1'b0;
      if (m_valid && m_ready) begin
         if (m_data !== dmodel(rx_n[5:0]) || m_last !== (rx_n == 63)) rx_bad++;
         if (rx_n == 63) fd_exp = 1'b1;
         rx_n++;
      end else if (m_last) begin
         if (rx_n != 63) rx_bad++;
      end
      prev_pend = m_valid && !m_ready;
      prev_dat  = m_data;
   endtask

   task automatic load_samples(input int n, input int gap);
      for (int j = 0; j < n; j++) begin
         if (gap != 0 && (j % gap) == gap - 1) begin
            @(negedge Clk); s_valid = 1'b0; obs();
         end
         @(negedge Clk);
         s_valid  = 1'b1;
         s_data   = smodel(6'(j));
         tf_valid = 1'b1;
         tf_data  = 32'hDEAD_BEEF;
         obs();
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      Reset = 1'b1; start = 1'b0; tf_reload = 1'b0; tf_valid = 1'b0; tf_data = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0; done_en = 1'b1; rnd_ready = 1'b0;
      clr();

      // Reset state
      repeat (3) @(negedge Clk);
      #1;
      chk("rst_fft_input", 64'(fft_input), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_flags", 64'({tf_ready, s_ready, m_valid, fft_write, fft_tf_we, frame_done, timeout_err}), 64'd0);
      chk("rst_addr", 64'({fft_addr, fft_addr_t}), 64'd0);
      chk("rst_run_cycles", 64'(run_cycles), 64'd0);
      @(negedge Clk); Reset = 1'b0;

      // Frame A: twiddles + samples with stalls, random 30% m_ready, start pulse during RUN
      clr(); rnd_ready = 1'b1;
      @(negedge Clk); start = 1'b1; tf_reload = 1'b1; obs();
      @(negedge Clk); start = 1'b0; tf_reload = 1'b0; obs();
      chk("a_tf_ready", 64'(tf_ready), 64'd1);
      chk("a_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 128; i++) begin
         if ((i % 7) == 3) begin
            @(negedge Clk); tf_valid = 1'b0; obs();
         end
         @(negedge Clk);
         tf_valid = 1'b1; tf_data = 32'(i);
         s_valid = 1'b1; s_data = 64'hBAD0_BAD0_BAD0_BAD0;
         obs();
      end
      @(negedge Clk); tf_valid = 1'b0; s_valid = 1'b0; obs();
      chk("a_tf_count", 64'(tf_we_n), 64'd128);
      chk("a_tf_addr_bad", 64'(tf_bad), 64'd0);
      chk("a_no_write_in_tf", 64'(wr_n), 64'd0);
      chk("a_s_ready", 64'({tf_ready, s_ready}), 64'b01);
      load_samples(64, 5);
      @(negedge Clk); s_valid = 1'b0; tf_valid = 1'b0; obs();
      chk("a_wr_count", 64'(wr_n), 64'd64);
      chk("a_wr_addr_bad", 64'(wr_bad), 64'd0);
      chk("a_no_tf_in_data", 64'(tf_we_n), 64'd128);
      chk("a_run_entry", 64'({fft_input, s_ready}), 64'b00);
      for (int k = 0; k < 3000 && fd_n == 0; k++) begin
         @(negedge Clk);
         start = (k == 10); tf_reload = (k == 10);
         obs();
      end
      @(negedge Clk); start = 1'b0; tf_reload = 1'b0; obs();
      chk("a_run_len", 64'(run_n), 64'd470);
      chk("a_rx_count", 64'(rx_n), 64'd64);
      chk("a_rx_bad", 64'(rx_bad), 64'd0);
      chk("a_valid_hold", 64'(hold_bad), 64'd0);
      chk("a_frame_done_n", 64'(fd_n), 64'd1);
      chk("a_frame_done_timing", 64'(fd_bad), 64'd0);
      chk("a_idle", 64'({busy, fft_input, timeout_err}), 64'b010);
`ifdef RFFT_SEQ_PERF_EN
      chk("a_run_cycles", 64'(run_cycles), 64'd470);
`else
      chk("a_run_cycles_tied", 64'(run_cycles), 64'd0);
`endif

      // Timeout: no twiddle reload, core never finishes
      clr(); rnd_ready = 1'b0; done_en = 1'b0;
      @(negedge Clk); start = 1'b1; tf_reload = 1'b0; obs();
      @(negedge Clk); start = 1'b0; obs();
      chk("t_direct_load", 64'({tf_ready, s_ready}), 64'b01);
      load_samples(64, 0);
      @(negedge Clk); s_valid = 1'b0; tf_valid = 1'b0; obs();
      for (int k = 0; k < 1200 && !timeout_err; k++) begin
         @(negedge Clk); obs();
      end
      chk("t_timeout_err", 64'(timeout_err), 64'd1);
      chk("t_run_len", 64'(run_n), 64'd1023);
      chk("t_idle", 64'({busy, fft_input}), 64'b01);
      chk("t_no_tf", 64'(tf_we_n), 64'd0);
`ifdef RFFT_SEQ_PERF_EN
      chk("t_run_cycles", 64'(run_cycles), 64'd1023);
`endif
      @(negedge Clk); start = 1'b1; obs();
      @(negedge Clk); start = 1'b0; obs();
      chk("t_err_cleared", 64'(timeout_err), 64'd0);

      // Reset while loading word 20
      clr();
      load_samples(20, 0);
      chk("r_partial_writes", 64'(wr_n), 64'd20);
      @(negedge Clk); Reset = 1'b1; s_valid = 1'b1; s_data = smodel(6'd20);
      #1;
      chk("r_fft_input", 64'(fft_input), 64'd1);
      chk("r_flags", 64'({busy, s_ready, fft_write, m_valid, timeout_err, frame_done}), 64'd0);
      chk("r_addr", 64'(fft_addr), 64'd0);
      chk("r_run_cycles", 64'(run_cycles), 64'd0);
      @(negedge Clk); Reset = 1'b0; s_valid = 1'b0; tf_valid = 1'b0;

      // Fresh frame after reset, always-ready output
      clr(); done_en = 1'b1;
      @(negedge Clk); start = 1'b1; tf_reload = 1'b0; obs();
      @(negedge Clk); start = 1'b0; obs();
      load_samples(64, 0);
      @(negedge Clk); s_valid = 1'b0; tf_valid = 1'b0; obs();
      chk("c_wr_count", 64'(wr_n), 64'd64);
      chk("c_wr_from_zero", 64'(wr_bad), 64'd0);
      chk("c_no_tf", 64'(tf_we_n), 64'd0);
      for (int k = 0; k < 2000 && fd_n == 0; k++) begin
         @(negedge Clk); obs();
      end
      @(negedge Clk); obs();
      chk("c_rx_count", 64'(rx_n), 64'd64);
      chk("c_rx_bad", 64'(rx_bad), 64'd0);
      chk("c_frame_done", 64'({fd_n[1:0], fd_bad[1:0]}), 64'b0100);
      chk("c_run_len", 64'(run_n), 64'd470);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rfft_seq_ctrl.md
Name: rfft_seq_ctrl

Overview:
- Sequencer that wraps the 256-point radix-4 FFT core.
- Loads twiddle factors and sample words through ready/valid streams, then releases the core to compute.
- Detects completion and streams the 64 result words out with backpressure.
- Owns every core control pin (input-mode, write, addresses, twiddle write-enable); the core is never driven directly by the host.

Parameters:
WIDTH, 16, bits per sample lane (core has 4 lanes per word)
NWORDS, 64, data words per frame (core address width 6)
TF_WORDS, 128, twiddle words written on a twiddle load (core twiddle address width 8)
RUN_TIMEOUT, 1023, max cycles in RUN before error

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous active-high reset
start  in  1  begin frame; sampled only in IDLE
tf_reload  in  1  sampled with start; 1 = load twiddles before data
tf_valid  in  1  twiddle stream valid
tf_ready  out  1  twiddle stream ready
tf_data  in  2*WIDTH  twiddle word
s_valid  in  1  sample stream valid
s_ready  out  1  sample stream ready
s_data  in  4*WIDTH  sample word, lane0 in LSBs
m_valid  out  1  result stream valid
m_ready  in  1  result stream ready
m_data  out  4*WIDTH  result word, lane0 in LSBs
m_last  out  1  marks word NWORDS-1
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after last result accepted
timeout_err  out  1  sticky; cleared by next accepted start
run_cycles  out  16  see Optional Feature
fft_input  out  1  core load/readout mode (1 = host owns RAM)
fft_write  out  1  core data RAM write enable
fft_addr  out  6  core data RAM address
fft_din  out  4*WIDTH  core data lanes 0..3
fft_tf_we  out  1  core twiddle RAM write enable
fft_addr_t  out  8  core twiddle RAM address
fft_dout  in  4*WIDTH  core RAM read data, 1-cycle registered latency
fft_done  in  1  core completion flag (level)

Behaviour:
- Reset values: fft_input=1 (core held halted), all other outputs 0, state IDLE, counters 0.
- States:
  - IDLE: start=1 → LOAD_TF if tf_reload else LOAD_DATA; clears timeout_err.
  - LOAD_TF: tf_ready=1. Each tf_valid&tf_ready pulses fft_tf_we in the same cycle, with fft_addr_t=tf count and twiddle word on the core twiddle input. After word TF_WORDS-1 → LOAD_DATA.
  - LOAD_DATA: s_ready=1. Each handshake gives fft_write=1, fft_addr=count, fft_din=s_data (combinational, same cycle). After word NWORDS-1 → RUN.
  - RUN: fft_input=0, fft_write=0, s_ready=0. Wait for fft_done=1 → READ. If RUN_TIMEOUT cycles elapse first: timeout_err=1, → IDLE with fft_input=1.
  - READ: fft_input=1, fft_write=0. Read address issued on fft_addr; fft_dout is valid the next cycle. Results go into a 2-entry output FIFO driving m_*. A read issues only if (FIFO occupancy + in-flight) < 2, so no data is dropped under any m_ready pattern. Addresses run 0..NWORDS-1 in order. When the word NWORDS-1 handshake completes: frame_done pulses and state → IDLE.
- Flow control: stream valid low stalls the count, no gaps written. Word counters wrap to 0 only on state exit.
- start outside IDLE is ignored. tf_valid/s_valid outside their state are ignored (ready=0).
- Reset mid-operation: immediate return to IDLE, fft_input=1, FIFO emptied, partial frame discarded.
- fft_addr_t is 0 outside LOAD_TF; fft_addr is 0 in IDLE and RUN.

Optional Feature:
RFFT_SEQ_PERF_EN:
- Defined: 16-bit counter clears on RUN entry and increments each RUN cycle, saturating at 16'hFFFF. run_cycles holds the final value of the last RUN until the next RUN entry.
- Not defined: run_cycles tied to 0 and no counter logic is built.

Test Plan:
- start with tf_reload=1 → 128 twiddle words (value = address) then 64 sample words → exactly 128 fft_tf_we pulses at addr_t 0..127, then 64 fft_write pulses at addr 0..63 → RUN.
- Core model asserts fft_done 470 cycles after RUN entry → 64 m_data words, addresses 0..63 in order, m_last only on word 63, frame_done one cycle after that handshake; with PERF_EN, run_cycles=470.
- m_ready random 30% during READ → no lost or duplicated words; m_valid never drops without a handshake.
- fft_done held 0 → timeout_err=1 after 1023 RUN cycles, back to IDLE with fft_input=1; next start clears timeout_err.
- Reset asserted at LOAD_DATA word 20 → outputs at reset values; a fresh start with tf_reload=0 goes straight to LOAD_DATA and writes from addr 0.
- start pulsed during RUN → ignored; frame completes normally.
